// File: rtl/qea_host_sequencer_if.sv
// Host-side stream bundle for the QEA sequencer: context and
// initial-state streams in, result-row stream out.
interface qea_host_sequencer_if #(
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64
);
    localparam int RW = PE_NUM * STATE_DATA_WIDTH;

    logic                               s_ctx_valid;
    logic                               s_ctx_ready;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] s_ctx_data;
    logic                               s_st_valid;
    logic                               s_st_ready;
    logic [RW-1:0]                      s_st_data;
    logic                               m_st_valid;
    logic                               m_st_ready;
    logic [RW-1:0]                      m_st_data;

    modport master (
        output s_ctx_valid, s_ctx_data,
        input  s_ctx_ready,
        output s_st_valid, s_st_data,
        input  s_st_ready,
        input  m_st_valid, m_st_data,
        output m_st_ready
    );

    modport slave (
        input  s_ctx_valid, s_ctx_data,
        output s_ctx_ready,
        input  s_st_valid, s_st_data,
        output s_st_ready,
        output m_st_valid, m_st_data,
        input  m_st_ready
    );
endinterface

// File: rtl/qea_host_sequencer.sv
// Host-side initiator for QEA: loads context/state RAMs, starts the
// core, times execution and streams the final state rows back out.
module qea_host_sequencer #(
    parameter int PE_NUM                  = 4,
    parameter int PE_NUM_WIDTH            = 2,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int READ_LATENCY            = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num,
    qea_host_sequencer_if.slave                host,
    output logic                               o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]          o_qea_qbit_num,
    output logic                               o_ctx_en,
    output logic                               o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data,
    output logic [PE_NUM-1:0]                  o_state_ena,
    output logic [PE_NUM-1:0]                  o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dina,
    input  logic                               i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_qea_state_dout,
    output logic                               o_busy,
    output logic                               o_done,
    output logic [31:0]                        o_exec_cycles
);
    localparam int RW    = PE_NUM * STATE_DATA_WIDTH;
    localparam int DEPTH = READ_LATENCY + 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int OW    = CW + 1;
    localparam int CAW   = GATE_CONTEXT_ADDR_WIDTH;
    localparam int SAW   = STATE_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CTX,
        S_LOAD_ST,
        S_START,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [MAX_QBIT_WIDTH-1:0] qbit_q, qbit_d;
    logic [CAW-1:0]            ins_q, ins_d;
    logic [SAW-1:0]            last_q, last_d;
    logic [CAW-1:0]            ctx_k_q, ctx_k_d;
    logic [SAW-1:0]            ld_row_q, ld_row_d;
    logic [SAW-1:0]            rd_addr_q, rd_addr_d;
    logic                      rd_all_q, rd_all_d;
    logic [SAW-1:0]            out_row_q, out_row_d;
    logic [31:0]               exec_q, exec_d;
    logic                      first_q, first_d;
    logic                      start_q, start_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [READ_LATENCY-1:0]   pipe_q, pipe_d;
    logic [RW-1:0]             mem_q [DEPTH];
    logic [RW-1:0]             mem_d [DEPTH];
    logic [PW-1:0]             wptr_q, wptr_d;
    logic [PW-1:0]             rptr_q, rptr_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    logic                      ctx_hs;
    logic                      st_hs;
    logic                      push;
    logic                      pop;
    logic                      issue;
    logic [CW-1:0]             inflight;
    logic [OW-1:0]             occ;
    logic [MAX_QBIT_WIDTH-1:0] shift;
    logic [SAW-1:0]            go_last;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ctx_hs = (state_q == S_LOAD_CTX) && host.s_ctx_valid;
    assign st_hs  = (state_q == S_LOAD_ST) && host.s_st_valid;
    assign push   = pipe_q[READ_LATENCY-1];
    assign pop    = (cnt_q != '0) && host.m_st_ready;

    // A read may issue only if every row in flight, plus this one,
    // is guaranteed a FIFO slot after this cycle's pop.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_q[i]);
        end
        occ   = OW'(cnt_q) + OW'(inflight) - OW'(pop);
        issue = (state_q == S_DRAIN) && !rd_all_q
                && (occ < OW'(DEPTH));
    end

    always_comb begin
        shift   = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
        go_last = '0;
        if (i_qbit_num >= MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) begin
            go_last = ~({SAW{1'b1}} << shift);
        end
    end

    always_comb begin
        state_d   = state_q;
        qbit_d    = qbit_q;
        ins_d     = ins_q;
        last_d    = last_q;
        ctx_k_d   = ctx_k_q;
        ld_row_d  = ld_row_q;
        rd_addr_d = rd_addr_q;
        rd_all_d  = rd_all_q;
        out_row_d = out_row_q;
        exec_d    = exec_q;
        first_d   = first_q;

        case (state_q)
            S_IDLE: begin
                if (i_go) begin
                    qbit_d    = i_qbit_num;
                    ins_d     = i_ins_num;
                    last_d    = go_last;
                    ctx_k_d   = '0;
                    ld_row_d  = '0;
                    rd_addr_d = '0;
                    rd_all_d  = 1'b0;
                    out_row_d = '0;
                    exec_d    = '0;
                    state_d   = (i_ins_num == '0) ? S_LOAD_ST : S_LOAD_CTX;
                end
            end
            S_LOAD_CTX: begin
                if (ctx_hs) begin
                    ctx_k_d = ctx_k_q + 1'b1;
                    if (ctx_k_q == ins_q - CAW'(1)) begin
                        state_d = S_LOAD_ST;
                    end
                end
            end
            S_LOAD_ST: begin
                if (st_hs) begin
                    ld_row_d = ld_row_q + 1'b1;
                    if (ld_row_q == last_q) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                exec_d  = '0;
                first_d = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                first_d = 1'b0;
                if (!first_q && i_qea_complete) begin
                    state_d = S_DRAIN;
                end else begin
                    exec_d = exec_q + 32'd1;
                end
            end
            S_DRAIN: begin
                if (issue) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (rd_addr_q == last_q) begin
                        rd_all_d = 1'b1;
                    end
                end
                if (pop) begin
                    out_row_d = out_row_q + 1'b1;
                    if (out_row_q == last_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_d = (state_d == S_START);
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_comb begin
        pipe_d[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q] = i_qea_state_dout;
        end
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            qbit_q    <= '0;
            ins_q     <= '0;
            last_q    <= '0;
            ctx_k_q   <= '0;
            ld_row_q  <= '0;
            rd_addr_q <= '0;
            rd_all_q  <= 1'b0;
            out_row_q <= '0;
            exec_q    <= '0;
            first_q   <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pipe_q    <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            qbit_q    <= qbit_d;
            ins_q     <= ins_d;
            last_q    <= last_d;
            ctx_k_q   <= ctx_k_d;
            ld_row_q  <= ld_row_d;
            rd_addr_q <= rd_addr_d;
            rd_all_q  <= rd_all_d;
            out_row_q <= out_row_d;
            exec_q    <= exec_d;
            first_q   <= first_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pipe_q    <= pipe_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign host.s_ctx_ready = (state_q == S_LOAD_CTX);
    assign host.s_st_ready  = (state_q == S_LOAD_ST);
    assign host.m_st_valid  = (cnt_q != '0);
    assign host.m_st_data   = mem_q[rptr_q];

    // RAM write ports follow the handshake combinationally.
    assign o_ctx_en      = ctx_hs;
    assign o_ctx_wea     = ctx_hs;
    assign o_ctx_addr    = ctx_hs ? ctx_k_q : '0;
    assign o_ctx_data    = ctx_hs ? host.s_ctx_data : '0;
    assign o_state_ena   = {PE_NUM{st_hs | issue}};
    assign o_state_wea   = {PE_NUM{st_hs}};
    assign o_state_addra = st_hs ? ld_row_q : (issue ? rd_addr_q : '0);
    assign o_state_dina  = st_hs ? host.s_st_data : '0;

    assign o_qea_start    = start_q;
    assign o_qea_qbit_num = qbit_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_exec_cycles  = exec_q;
endmodule

// File: tb/tb_qea_host_sequencer.sv
// Directed bench for qea_host_sequencer with a latency-2 state RAM
// model and a QEA completion model driven from a vector table.
module tb_qea_host_sequencer;
    localparam int RW = 256;

    typedef struct {
        int qbit;
        int ins;
        bit cgap;
        bit sgap;
        bit rrdy;
        int cdel;
        int rows;
        int exec;
        bit spec;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_go = 1'b0;
    logic [5:0]    i_qbit_num = '0;
    logic [15:0]   i_ins_num = '0;
    logic          i_qea_complete = 1'b0;
    logic [RW-1:0] i_qea_state_dout;
    logic          o_qea_start;
    logic [5:0]    o_qea_qbit_num;
    logic          o_ctx_en;
    logic          o_ctx_wea;
    logic [15:0]   o_ctx_addr;
    logic [63:0]   o_ctx_data;
    logic [3:0]    o_state_ena;
    logic [3:0]    o_state_wea;
    logic [15:0]   o_state_addra;
    logic [RW-1:0] o_state_dina;
    logic          o_busy;
    logic          o_done;
    logic [31:0]   o_exec_cycles;

    int total = 0;
    int bad = 0;
    vec_t vecs [7];
    logic [63:0]   ctx_src [0:255];
    logic [RW-1:0] st_src [0:63];
    logic [RW-1:0] sram [0:63];
    logic [RW-1:0] rd1;
    logic [RW-1:0] rd2;

    qea_host_sequencer_if #(
        .PE_NUM(4),
        .STATE_DATA_WIDTH(64),
        .GATE_CONTEXT_DATA_WIDTH(64)
    ) host ();

    qea_host_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_go(i_go),
        .i_qbit_num(i_qbit_num),
        .i_ins_num(i_ins_num),
        .host(host.slave),
        .o_qea_start(o_qea_start),
        .o_qea_qbit_num(o_qea_qbit_num),
        .o_ctx_en(o_ctx_en),
        .o_ctx_wea(o_ctx_wea),
        .o_ctx_addr(o_ctx_addr),
        .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena),
        .o_state_wea(o_state_wea),
        .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina),
        .i_qea_complete(i_qea_complete),
        .i_qea_state_dout(i_qea_state_dout),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_exec_cycles(o_exec_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_state_wea == 4'hF) sram[o_state_addra[5:0]] <= o_state_dina;
        if (o_state_ena == 4'hF && o_state_wea == 4'h0)
            rd1 <= sram[o_state_addra[5:0]];
        rd2 <= rd1;
    end
    assign i_qea_state_dout = rd2;

    task automatic chk(input string nm, input logic [RW-1:0] got,
                       input logic [RW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic src_ctx(input int n, input bit gaps);
        bit hs;
        for (int k = 0; k < n; k++) begin
            host.s_ctx_valid = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            host.s_ctx_valid = 1'b1;
            host.s_ctx_data  = ctx_src[k];
            hs = 1'b0;
            for (int t = 0; t < 3000 && !hs; t++) begin
                @(negedge clk); hs = host.s_ctx_ready;
                @(posedge clk); #1;
            end
            if (!hs) break;
        end
        host.s_ctx_valid = 1'b0;
    endtask

    task automatic src_st(input int n, input bit gaps);
        bit hs;
        for (int r = 0; r < n; r++) begin
            host.s_st_valid = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            host.s_st_valid = 1'b1;
            host.s_st_data  = st_src[r];
            hs = 1'b0;
            for (int t = 0; t < 3000 && !hs; t++) begin
                @(negedge clk); hs = host.s_st_ready;
                @(posedge clk); #1;
            end
            if (!hs) break;
        end
        host.s_st_valid = 1'b0;
    endtask

    task automatic monitor(input vec_t v);
        int c = 0;
        int ctx_n = 0;
        int st_n = 0;
        int out_n = 0;
        int starts = 0;
        int start_c = -1;
        int stale = 0;
        bit done = 1'b0;
        bit stall = 1'b0;
        logic [RW-1:0] pdata = '0;
        while (!done && c < 5000) begin
            @(negedge clk);
            host.m_st_ready = v.rrdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (start_c >= 0 && v.cdel > 0 && c == start_c + v.cdel + 1)
                i_qea_complete = 1'b1;
            #1;
            if (o_ctx_en) begin
                chk("ctx_addr", RW'(o_ctx_addr), RW'(ctx_n));
                chk("ctx_data", RW'(o_ctx_data), RW'(ctx_src[ctx_n[7:0]]));
                chk("ctx_wea", RW'(o_ctx_wea), RW'(1));
                ctx_n++;
            end
            if (o_state_wea != 4'h0) begin
                chk("st_addr", RW'(o_state_addra), RW'(st_n));
                chk("st_data", o_state_dina, st_src[st_n[5:0]]);
                chk("st_en", RW'({o_state_ena, o_state_wea}), RW'(8'hFF));
                st_n++;
            end
            if (o_qea_start) begin
                starts++;
                chk("rows_before_start", RW'(st_n), RW'(v.rows));
                start_c = c;
                if (v.cdel == 0) i_qea_complete = 1'b1;
            end
            if (start_c < 0 && host.m_st_valid) stale++;
            if (stall)
                chk("m_st_hold", {host.m_st_valid, host.m_st_data[254:0]},
                    {1'b1, pdata[254:0]});
            if (host.m_st_valid && host.m_st_ready) begin
                chk("m_st_data", host.m_st_data, st_src[out_n[5:0]]);
                out_n++;
            end
            stall = host.m_st_valid && !host.m_st_ready;
            pdata = host.m_st_data;
            if (o_done) done = 1'b1;
            c++;
        end
        chk("done_seen", RW'(done), RW'(1));
        chk("exec_cycles", RW'(o_exec_cycles), RW'(v.exec));
        chk("ctx_count", RW'(ctx_n), RW'(v.ins));
        chk("st_count", RW'(st_n), RW'(v.rows));
        chk("out_count", RW'(out_n), RW'(v.rows));
        chk("start_count", RW'(starts), RW'(1));
        chk("stale_out", RW'(stale), RW'(0));
        chk("busy_at_done", RW'(o_busy), RW'(0));
        i_qea_complete = 1'b0;
    endtask

    task automatic fill_src(input vec_t v);
        for (int k = 0; k < 256; k++) ctx_src[k] = {$urandom, $urandom};
        for (int r = 0; r < 64; r++)
            st_src[r] = v.spec ? '0 : {$urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom, $urandom};
        if (v.spec) st_src[0] = {192'h0, 64'h4000000000000000};
    endtask

    task automatic pulse_go(input int qbit, input int ins);
        i_go = 1'b1;
        i_qbit_num = 6'(qbit);
        i_ins_num = 16'(ins);
        @(posedge clk); #1;
        i_go = 1'b0;
    endtask

    task automatic run_job(input vec_t v);
        fill_src(v);
        pulse_go(v.qbit, v.ins);
        chk("busy_after_go", RW'(o_busy), RW'(1));
        chk("qbit_latched", RW'(o_qea_qbit_num), RW'(v.qbit));
        fork
            src_ctx(v.ins, v.cgap);
            src_st(v.rows, v.sgap);
            monitor(v);
        join
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{4, 115, 0, 0, 0, 50, 4, 50, 1};
        vecs[1] = '{2, 0, 0, 0, 0, 5, 1, 5, 0};
        vecs[2] = '{6, 8, 0, 0, 1, 3, 16, 3, 0};
        vecs[3] = '{3, 20, 1, 1, 0, 10, 2, 10, 0};
        vecs[4] = '{4, 4, 0, 0, 0, 0, 4, 1, 0};
        vecs[5] = '{0, 1, 0, 1, 1, 2, 1, 2, 0};
        vecs[6] = '{5, 6, 1, 0, 1, 7, 8, 7, 0};
        host.s_ctx_valid = 1'b0;
        host.s_ctx_data  = '0;
        host.s_st_valid  = 1'b0;
        host.s_st_data   = '0;
        host.m_st_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", RW'(o_busy), RW'(0));
        chk("rst_start", RW'(o_qea_start), RW'(0));
        chk("rst_done", RW'(o_done), RW'(0));
        chk("rst_exec", RW'(o_exec_cycles), RW'(0));
        chk("rst_ready", RW'({host.s_ctx_ready, host.s_st_ready}), RW'(0));
        chk("rst_m_valid", RW'(host.m_st_valid), RW'(0));
        chk("rst_ram", RW'({o_ctx_en, o_state_ena}), RW'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_job(vecs[i]);

        fill_src(vecs[1]);
        pulse_go(4, 2);
        src_ctx(2, 1'b0);
        src_st(1, 1'b0);
        pulse_go(6, 0);
        chk("go_ignored_qbit", RW'(o_qea_qbit_num), RW'(4));
        chk("go_ignored_busy", RW'(o_busy), RW'(1));
        chk("mid_st_ready", RW'(host.s_st_ready), RW'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", RW'(o_busy), RW'(0));
        chk("arst_st_ready", RW'(host.s_st_ready), RW'(0));
        chk("arst_qbit", RW'(o_qea_qbit_num), RW'(0));
        chk("arst_m_valid", RW'(host.m_st_valid), RW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(vecs[6]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
